// File: rtl/mbs_pkg.sv
// mbs_pkg: shared state encoding and width constants for the mbs multiplier (rev 1.0)
`default_nettype none

package mbs_pkg;

  localparam int N_DEF = 8;
  localparam int CNT_W = $clog2(N_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mbs_datapath.sv
// mbs_datapath: shift registers, accumulator and iteration counter for shift-and-add (rev 1.0)
`default_nettype none

module mbs_datapath
  import mbs_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CNT_W
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic [2*N-1:0] sum,
  output logic           last
);

  logic [2*N-1:0] a_q;
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] mcand_ext;
  logic [2*N-1:0] addend;

  assign mcand_ext = {{N{1'b0}}, mcand};
  assign addend    = b_q[0] ? a_q : '0;
  // Accumulator value after the iteration currently being processed.
  assign sum       = acc_q + addend;
  assign last      = (cnt_q == CW'(N - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      // Iteration 0 is folded into the capture edge.
      a_q   <= mcand_ext << 1;
      b_q   <= mplier >> 1;
      acc_q <= mplier[0] ? mcand_ext : '0;
      cnt_q <= CW'(1);
    end else if (step) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      acc_q <= sum;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mbs.sv
// mbs: unsigned N x N sequential shift-and-add multiplier, one multiplier bit per clock (rev 1.0)
`default_nettype none

module mbs
  import mbs_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic [2*N-1:0] produto,
  output logic           finish
);

  localparam int CW = $clog2(N) + 1;

  state_e         state_q, state_d;
  logic [2*N-1:0] produto_q, produto_d;
  logic           load, step;
  logic [2*N-1:0] sum;
  logic           last;

  mbs_datapath #(
    .N  (N),
    .CW (CW)
  ) u_datapath (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .mcand   (multiplicando),
    .mplier  (multiplicador),
    .sum     (sum),
    .last    (last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      produto_q <= '0;
    end else begin
      state_q   <= state_d;
      produto_q <= produto_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    produto_d = produto_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          produto_d = sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Held start must not retrigger; wait for it to drop.
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign produto = produto_q;
  assign finish  = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mbs.sv
// tb_mbs: randomized scoreboard bench for the mbs multiplier (rev 1.0)
`default_nettype none

module tb_mbs;

  localparam int N = 8;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   multiplicando = '0;
  logic [N-1:0]   multiplicador = '0;
  logic [2*N-1:0] produto;
  logic           finish;

  int total = 0;
  int bad   = 0;
  logic [2*N-1:0] exp_q[$];

  mbs #(.N(N)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .produto       (produto),
    .finish        (finish)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Monitor: on each rising of finish, pop the expected product and compare.
  initial begin
    logic fin_prev;
    fin_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && finish && !fin_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_finish", 32'(finish), 32'd0);
        end else begin
          chk("product", 32'(produto), 32'(exp_q.pop_front()));
        end
      end
      fin_prev = finish;
    end
  end

  // One multiplication; operands switch to (ca,cb) after edge chg_edge (0 = never).
  task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                         input int chg_edge, input logic [N-1:0] ca, input logic [N-1:0] cb);
    logic [2*N-1:0] expv;
    expv = (2*N)'(a) * (2*N)'(b);
    @(negedge clock);
    multiplicando = a;
    multiplicador = b;
    start = 1'b1;
    exp_q.push_back(expv);
    for (int i = 1; i <= N; i++) begin
      @(posedge clock);
      #1;
      if (i == chg_edge) begin
        multiplicando = ca;
        multiplicador = cb;
      end
      if (i < N) begin
        if (finish !== 1'b0) chk("early_finish", 32'(finish), 32'd0);
      end else begin
        chk("latency_finish", 32'(finish), 32'd1);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      chk("hold_finish", 32'(finish), 32'd1);
      chk("hold_produto", 32'(produto), 32'(expv));
    end
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("drop_finish", 32'(finish), 32'd0);
    chk("idle_produto", 32'(produto), 32'(expv));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("reset_produto", 32'(produto), 32'd0);
    chk("reset_finish", 32'(finish), 32'd0);
    #20;
    @(negedge clock);
    reset_n = 1'b1;

    do_mult(8'd42, 8'd13, 2, 0, '0, '0);
    do_mult(8'd255, 8'd255, 0, 0, '0, '0);
    do_mult(8'd0, 8'd200, 0, 0, '0, '0);
    do_mult(8'd200, 8'd0, 0, 0, '0, '0);
    do_mult(8'd1, 8'd1, 10, 0, '0, '0);
    do_mult(8'd7, 8'd6, 0, 0, '0, '0);
    do_mult(8'd42, 8'd13, 1, 3, 8'd3, 8'd3);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clock);
    multiplicando = 8'd100;
    multiplicador = 8'd100;
    start = 1'b1;
    for (int i = 1; i <= 4; i++) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_produto", 32'(produto), 32'd0);
    chk("async_finish", 32'(finish), 32'd0);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    do_mult(8'd5, 8'd9, 0, 0, '0, '0);

    for (int k = 0; k < 24; k++) begin
      do_mult(N'($urandom), N'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, N - 1)), N'($urandom), N'($urandom));
    end

    repeat (3) @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
